// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a double-width accumulator.
// Optional early termination when the remaining multiplier bits are all equal: BOOTH_EARLY_TERM_EN.
module booth_radix4_seq_mult #(
    parameter int WORDLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [WORDLEN-1:0]     in_a,
    input  logic [WORDLEN-1:0]     in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WORDLEN-1:0]   out_product
);

    localparam int NDIG = WORDLEN / 2 + 1;
    localparam int AW   = WORDLEN + 2;
    localparam int PW   = 2 * WORDLEN + 4;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]          a_ext;
    logic [AW:0]            b_sh;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          acc_nxt;
    logic [CW-1:0]          digit_cnt;
    logic [2*WORDLEN-1:0]   product_q;

    logic                   accept;
    logic                   last_digit;
    logic                   rest_zero;
    logic                   finish;

    logic [2:0]             triplet;
    logic                   dig_neg;
    logic                   dig_dbl;
    logic                   dig_zero;
    logic [PW-1:0]          a_wide;
    logic [PW-1:0]          magnitude;
    logic [PW-1:0]          shifted;
    logic [PW-1:0]          addend;
    logic [CW:0]            shift_amt;

    assign accept     = in_valid && in_ready;
    assign last_digit = (digit_cnt == CW'(NDIG - 1));

    // b_sh[2:0] always holds the current triplet {B[2i+1], B[2i], B[2i-1]}
    always_comb begin
        triplet  = b_sh[2:0];
        dig_neg  = 1'b0;
        dig_dbl  = 1'b0;
        dig_zero = 1'b0;
        unique case (triplet)
            3'b000, 3'b111: dig_zero = 1'b1;
            3'b001, 3'b010: dig_neg  = 1'b0;
            3'b011:         dig_dbl  = 1'b1;
            3'b100: begin
                dig_dbl = 1'b1;
                dig_neg = 1'b1;
            end
            3'b101, 3'b110: dig_neg  = 1'b1;
            default:        dig_zero = 1'b1;
        endcase
    end

    // Negative digits add the inverted partial product with a carry-in of one
    always_comb begin
        a_wide    = {{(PW - AW){a_ext[AW-1]}}, a_ext};
        shift_amt = {digit_cnt, 1'b0};
        if (dig_zero) begin
            magnitude = '0;
        end else if (dig_dbl) begin
            magnitude = a_wide << 1;
        end else begin
            magnitude = a_wide;
        end
        shifted = magnitude << shift_amt;
        addend  = dig_neg ? ~shifted : shifted;
        acc_nxt = acc + addend + {{(PW - 1){1'b0}}, dig_neg};
    end

`ifdef BOOTH_EARLY_TERM_EN
    // Remaining digits are all zero once the unprocessed bits are a pure sign run
    always_comb begin
        rest_zero = (&b_sh[AW:2]) | ~(|b_sh[AW:2]);
    end
`else
    assign rest_zero = 1'b0;
`endif

    assign finish = last_digit || rest_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        out_product = product_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext     <= '0;
            b_sh      <= '0;
            acc       <= '0;
            digit_cnt <= '0;
            product_q <= '0;
        end else if (accept) begin
            a_ext     <= in_signed ? {{2{in_a[WORDLEN-1]}}, in_a} : {2'b00, in_a};
            b_sh      <= in_signed ? {{2{in_b[WORDLEN-1]}}, in_b, 1'b0} : {2'b00, in_b, 1'b0};
            acc       <= '0;
            digit_cnt <= '0;
        end else if (state == RUN) begin
            acc       <= acc_nxt;
            digit_cnt <= digit_cnt + CW'(1);
            b_sh      <= {{2{b_sh[AW]}}, b_sh[AW:2]};
            if (finish) begin
                product_q <= acc_nxt[2*WORDLEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed bench for booth_radix4_seq_mult at WORDLEN=8 with hand-computed products.
// Latency expectations follow BOOTH_EARLY_TERM_EN when it is defined.
module tb_booth_radix4_seq_mult;

    localparam int W = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_signed;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_product;

    int checks;
    int failures;

    booth_radix4_seq_mult #(.WORDLEN(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and waits for out_valid; leaves time at #1 after that edge
    task automatic apply_stimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, input logic [2*W-1:0] expected, input int exp_lat);
        int lat;
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_output({tag, "_product"}, 32'(out_product), 32'(expected));
        if (exp_lat > 0) begin
            check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        logic [2*W-1:0] rexp;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_product", 32'(out_product), 32'd0);
        rst = 1'b0;
        tick();

`ifdef BOOTH_EARLY_TERM_EN
        apply_stimulus("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000, 4);
`else
        apply_stimulus("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000, 5);
`endif
        tick();
        check_output("s_m128_m128_idle", 32'(out_valid), 32'd0);

        apply_stimulus("u_255_255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, -1);
        tick();
        apply_stimulus("s_m1_m1", 8'hFF, 8'hFF, 1'b1, 16'h0001, -1);
        tick();
        apply_stimulus("s_m1_1", 8'hFF, 8'h01, 1'b1, 16'hFFFF, -1);
        tick();
        apply_stimulus("u_0_200", 8'h00, 8'hC8, 1'b0, 16'h0000, -1);
        tick();

        out_ready = 1'b0;
        apply_stimulus("bp_3_m5", 8'h03, 8'hFB, 1'b1, 16'hFFF1, -1);
        in_a      = 8'h11;
        in_b      = 8'h22;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("bp_hold_valid", 32'(out_valid), 32'd1);
            check_output("bp_hold_product", 32'(out_product), 32'h0000FFF1);
            check_output("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_output("bp_release_valid", 32'(out_valid), 32'd0);
        check_output("bp_release_in_ready", 32'(in_ready), 32'd1);

        in_a      = 8'h64;
        in_b      = 8'h64;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_mid_valid", 32'(out_valid), 32'd0);
        check_output("rst_mid_product", 32'(out_product), 32'd0);
        check_output("rst_mid_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output("rst_mid_no_emit", 32'(out_valid), 32'd0);
        end
        apply_stimulus("u_7_9", 8'h07, 8'h09, 1'b0, 16'h003F, -1);
        tick();

`ifdef BOOTH_EARLY_TERM_EN
        apply_stimulus("u_100_3", 8'h64, 8'h03, 1'b0, 16'h012C, 2);
`else
        apply_stimulus("u_100_3", 8'h64, 8'h03, 1'b0, 16'h012C, 5);
`endif
        tick();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(1, 0));
            if (rs) begin
                rexp = 16'($signed({{8{ra[W-1]}}, ra}) * $signed({{8{rb[W-1]}}, rb}));
            end else begin
                rexp = 16'({8'h00, ra} * {8'h00, rb});
            end
            apply_stimulus("rand", ra, rb, rs, rexp, -1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
